// File: rtl/oam_dma_ctrl_if.sv
// Bus bundle around the OAM DMA controller: the CPU side, external memory, HRAM and the OAM write port.
// The master modport is the controller's view. The slave modport is the view of the surrounding CPU and memories.
interface oam_dma_ctrl_if;
    logic        cpu_rd_en;
    logic        cpu_wr_en;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        hram_rd_en;
    logic        hram_wr_en;
    logic [6:0]  hram_addr;
    logic [7:0]  hram_wdata;
    logic [7:0]  hram_rdata;
    logic        oam_we;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;
    logic        dma_active;

    modport master (
        input  cpu_rd_en, cpu_wr_en, cpu_addr, cpu_wdata, mem_rdata, hram_rdata,
        output cpu_rdata, mem_rd_en, mem_wr_en, mem_addr, mem_wdata,
               hram_rd_en, hram_wr_en, hram_addr, hram_wdata,
               oam_we, oam_addr, oam_wdata, dma_active
    );

    modport slave (
        output cpu_rd_en, cpu_wr_en, cpu_addr, cpu_wdata, mem_rdata, hram_rdata,
        input  cpu_rdata, mem_rd_en, mem_wr_en, mem_addr, mem_wdata,
               hram_rd_en, hram_wr_en, hram_addr, hram_wdata,
               oam_we, oam_addr, oam_wdata, dma_active
    );
endinterface

// File: rtl/oam_dma_ctrl.sv
// The OAM DMA register at FF46 and the engine behind it. It copies {src,00..9F} into OAM.
// While a copy runs, the engine owns the external bus and the CPU can only reach HRAM and FF46.
module oam_dma_ctrl #(
    parameter int CYCLES_PER_BYTE = 4,
    parameter int OAM_LEN         = 160
) (
    input  logic           clk,
    input  logic           rst,
    oam_dma_ctrl_if.master bus
);
    localparam int PW = (CYCLES_PER_BYTE > 1) ? $clog2(CYCLES_PER_BYTE) : 1;

    typedef enum logic [1:0] {IDLE, START, XFER} state_t;

    state_t          state;
    logic [7:0]      dma_reg;
    logic [7:0]      src;
    logic [7:0]      idx;
    logic [PW-1:0]   pace;

    logic is_hram, is_reg, is_ext;
    logic cpu_wr, cpu_rd;
    logic xfer, byte_slot, pace_wrap, last_byte;

    assign is_hram   = (bus.cpu_addr >= 16'hFF80) && (bus.cpu_addr <= 16'hFFFE);
    assign is_reg    = (bus.cpu_addr == 16'hFF46);
    assign is_ext    = !is_hram && !is_reg;
    // A simultaneous read and write strobe is treated as a write.
    assign cpu_wr    = bus.cpu_wr_en;
    assign cpu_rd    = bus.cpu_rd_en && !bus.cpu_wr_en;
    assign xfer      = (state == XFER);
    assign byte_slot = xfer && (pace == '0);
    assign pace_wrap = (pace == PW'(CYCLES_PER_BYTE - 1));
    assign last_byte = (idx == 8'(OAM_LEN - 1));

    assign bus.dma_active = xfer;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            dma_reg <= 8'hFF;
            src     <= 8'h00;
            idx     <= 8'h00;
            pace    <= '0;
        end else if (cpu_wr && is_reg) begin
            dma_reg <= bus.cpu_wdata;
            state   <= START;
        end else begin
            case (state)
                IDLE: state <= IDLE;
                START: begin
                    // Sources E0-FF fall in echo RAM, so they are folded back onto C0-DF.
                    src   <= (dma_reg >= 8'hE0) ? (dma_reg - 8'h20) : dma_reg;
                    idx   <= 8'h00;
                    pace  <= '0;
                    state <= XFER;
                end
                XFER: begin
                    if (pace_wrap) begin
                        pace <= '0;
                        if (last_byte) state <= IDLE;
                        else           idx   <= idx + 8'h01;
                    end else begin
                        pace <= pace + PW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.cpu_rdata  = 8'h00;
        bus.mem_rd_en  = 1'b0;
        bus.mem_wr_en  = 1'b0;
        bus.mem_addr   = 16'h0000;
        bus.mem_wdata  = 8'h00;
        bus.hram_rd_en = 1'b0;
        bus.hram_wr_en = 1'b0;
        bus.hram_addr  = 7'h00;
        bus.hram_wdata = 8'h00;
        bus.oam_we     = 1'b0;
        bus.oam_addr   = 8'h00;
        bus.oam_wdata  = 8'h00;

        if (is_hram) begin
            bus.hram_rd_en = cpu_rd;
            bus.hram_wr_en = cpu_wr;
            if (cpu_rd || cpu_wr) bus.hram_addr = bus.cpu_addr[6:0];
            if (cpu_wr) bus.hram_wdata = bus.cpu_wdata;
            if (cpu_rd) bus.cpu_rdata = bus.hram_rdata;
        end else if (is_reg) begin
            if (cpu_rd) bus.cpu_rdata = dma_reg;
        end else if (is_ext && xfer) begin
            if (cpu_rd) bus.cpu_rdata = 8'hFF;
        end else if (is_ext) begin
            bus.mem_rd_en = cpu_rd;
            bus.mem_wr_en = cpu_wr;
            if (cpu_rd || cpu_wr) bus.mem_addr = bus.cpu_addr;
            if (cpu_wr) bus.mem_wdata = bus.cpu_wdata;
            if (cpu_rd) bus.cpu_rdata = bus.mem_rdata;
        end

        // A copy slot uses only registered state for the address. The read data passes straight into OAM.
        if (byte_slot) begin
            bus.mem_rd_en = 1'b1;
            bus.mem_addr  = {src, idx};
            bus.oam_we    = 1'b1;
            bus.oam_addr  = idx;
            bus.oam_wdata = bus.mem_rdata;
        end
    end
endmodule

// File: doc/oam_dma_ctrl.md
Name: oam_dma_ctrl

Overview:
- Owns the OAM DMA register (FF46) and arbitrates the external memory bus between the CPU core and the DMA engine.
- A CPU write to FF46 copies 160 bytes from {src,8'h00}..{src,8'h9F} to the OAM write port (FE00–FE9F).
- While the copy runs, the CPU may only reach HRAM (FF80–FFFE) and FF46; all other CPU accesses are blocked.
- Sits between the cpu bus outputs (rd_en/wr_en/addr_out/data_out/data_in) and the memory map.

Parameters:
- CYCLES_PER_BYTE, 4, clk cycles per transferred byte (>=1).
- OAM_LEN, 160, bytes per transfer.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- cpu_rd_en  in  1  CPU read strobe
- cpu_wr_en  in  1  CPU write strobe
- cpu_addr  in  16  CPU address
- cpu_wdata  in  8  CPU write data
- cpu_rdata  out  8  read data returned to CPU (combinational)
- mem_rd_en  out  1  memory read strobe
- mem_wr_en  out  1  memory write strobe
- mem_addr  out  16  memory address
- mem_wdata  out  8  memory write data
- mem_rdata  in  8  memory read data, valid in the same cycle as mem_rd_en (asynchronous read)
- hram_rd_en  out  1  HRAM read strobe
- hram_wr_en  out  1  HRAM write strobe
- hram_addr  out  7  HRAM offset (cpu_addr[6:0])
- hram_wdata  out  8  HRAM write data
- hram_rdata  in  8  HRAM read data, same-cycle
- oam_we  out  1  OAM write strobe
- oam_addr  out  8  OAM byte index 0..159
- oam_wdata  out  8  OAM write data
- dma_active  out  1  high while in XFER

Behaviour:
- Reset:
  - State IDLE; dma_reg=8'hFF; idx=0; pace=0.
  - All strobes 0, dma_active 0; addresses and data outputs 0.
- Address decode:
  - HRAM = FF80–FFFE.
  - REG = FF46.
  - Everything else = EXT.
- HRAM:
  - Always routed to the hram_* port, independent of state.
- REG:
  - A write latches dma_reg and starts or restarts a transfer.
  - A read returns dma_reg.
  - Never forwarded to mem.
- States:
  - IDLE: the CPU owns the mem bus. EXT accesses pass straight through (mem_* = cpu_*), and cpu_rdata = mem_rdata.
  - START: exactly 1 cycle. Latch src = dma_reg; if src >= 8'hE0, use src - 8'h20 (echo RAM mapping). Clear idx and pace. The CPU still owns the bus. Go to XFER.
  - XFER: the DMA owns the mem bus.
    - In each cycle with pace==0: mem_rd_en=1, mem_addr={src,idx}, oam_we=1, oam_addr=idx, oam_wdata=mem_rdata.
    - pace counts 0..CYCLES_PER_BYTE-1 and wraps; idx increments on the cycle pace wraps to 0.
    - On the wrap after idx==OAM_LEN-1, go to IDLE.
    - mem_wr_en=0 throughout.
- Total duration from the FF46 write cycle: 1 (write) + 1 (START) + OAM_LEN*CYCLES_PER_BYTE cycles in XFER. With defaults, dma_active is high for exactly 640 cycles.
- CPU during XFER:
  - EXT reads return 8'hFF and do not drive mem.
  - EXT writes are dropped.
  - HRAM and REG accesses are unaffected.
- FF46 write during START or XFER:
  - Any byte transfer scheduled in that same cycle completes.
  - Next cycle: state=START with the new dma_reg, then the transfer restarts from idx 0.
  - dma_active drops for the START cycle.
- cpu_rd_en and cpu_wr_en asserted together: treat as a write.
- CYCLES_PER_BYTE=1: one byte per cycle, pace constantly 0.
- rst mid-transfer: return to IDLE immediately, dma_reg=8'hFF, no further OAM writes; OAM contents already written are not reverted.
- No combinational path from mem_rdata to any mem_* output.

Test Plan:
- Basic copy:
  - Stimulus: preload 0xC000–0xC09F with i^0x5A; CPU writes 8'hC0 to FF46.
  - Response: 160 oam_we pulses, oam_addr 0..159, data i^0x5A, spaced 4 cycles apart; dma_active high for 640 cycles; then IDLE.
- Blocking:
  - Stimulus: during XFER, CPU reads 0xC000, writes 0xD000=8'h12, reads and writes 0xFF90.
  - Response: cpu_rdata=8'hFF; no mem write; HRAM write and readback correct.
- Register readback:
  - Reset → read FF46 = 8'hFF.
  - Write 8'h80 → read FF46 = 8'h80, both during XFER and after.
- Restart:
  - Stimulus: at idx=50, CPU writes 8'hD0 to FF46.
  - Response: one START cycle, then oam_addr restarts at 0 with source 0xD000; 160 further writes.
- Echo and reset:
  - Stimulus: source 8'hE1.
  - Response: mem_addr starts at 0xC100.
  - Stimulus: assert rst at idx=10.
  - Response: next cycle, strobes 0, dma_active 0, no further oam_we.
- Pass-through:
  - Stimulus: in IDLE, CPU reads 0x1234 then writes 0xC000=8'hAB.
  - Response: mem_* mirror cpu_*; cpu_rdata = mem_rdata in the same cycle.
